matrix_load_ctrl: RTL

- Sequencer in front of the 5x5 matrix reorder block.
- Accepts matrix dimensions, then collects r*c elements serially over a valid/ready stream into a compact 25-entry buffer.
- Then drives the reorder block's enable with the latched dimensions for a fixed window, and reports done.
- Sits between the input front-end (switch/UART element source) and the reorder/display path.

---
 rtl/matrix_load_ctrl_pkg.sv | 22 ++
 rtl/matrix_load_ctrl_if.sv | 36 +++
 rtl/matrix_elem_buffer.sv | 41 ++++
 rtl/matrix_load_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/matrix_load_ctrl_pkg.sv
// Shared definitions for the matrix load sequencer: state encoding,
// buffer geometry and the dimension legality check.
package matrix_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ORDER = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Buffer holds a full MAX_DIM x MAX_DIM matrix in compact row-major order.
    localparam int MAT_ENTRIES = 25;
    localparam int IDX_W       = 5;
    localparam int MAX_DIM     = 5;

    // A dimension is usable when it is non-zero and fits the buffer geometry.
    function automatic logic dim_legal(input logic [2:0] d, input int max_dim);
        return (d != 3'd0) && (int'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_load_ctrl_if.sv
// Bundle of command, element stream and reorder-side signals between the
// element source, the load sequencer and the reorder/display path.
interface matrix_load_ctrl_if #(
    parameter int DATA_WIDTH = 9
);
    import matrix_load_ctrl_pkg::*;

    logic                              start;
    logic                              cancel;
    logic [2:0]                        dim_r;
    logic [2:0]                        dim_c;
    logic                              in_valid;
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              in_ready;
    logic [2:0]                        ord_r;
    logic [2:0]                        ord_c;
    logic                              ord_en;
    logic [MAT_ENTRIES*DATA_WIDTH-1:0] buf_flat;
    logic [IDX_W-1:0]                  count;
    logic                              busy;
    logic                              done;
    logic                              err;

    // Element source / command side.
    modport master (
        output start, cancel, dim_r, dim_c, in_valid, in_data,
        input  in_ready, ord_r, ord_c, ord_en, buf_flat, count, busy, done, err
    );

    // Load sequencer side.
    modport slave (
        input  start, cancel, dim_r, dim_c, in_valid, in_data,
        output in_ready, ord_r, ord_c, ord_en, buf_flat, count, busy, done, err
    );

endinterface

// File: rtl/matrix_elem_buffer.sv
// 25-entry element register file with bulk clear, single write port and a
// flat read-out that the reorder block consumes directly.
module matrix_elem_buffer
    import matrix_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_clear,
    input  logic                              i_we,
    input  logic [IDX_W-1:0]                  i_waddr,
    input  logic [DATA_WIDTH-1:0]             i_wdata,
    output logic [MAT_ENTRIES*DATA_WIDTH-1:0] o_buf_flat
);

    logic [DATA_WIDTH-1:0] r_mem [MAT_ENTRIES];

    // Entry storage: reset/clear zero every entry, otherwise write one entry.
    // NOTE: this storage is reset on purpose -- downstream displays unused
    // entries as zero, so it must be flops, not an inferred RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAT_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < MAT_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Entry k lands at bits [k*DATA_WIDTH +: DATA_WIDTH].
    for (genvar g = 0; g < MAT_ENTRIES; g++) begin : g_flat
        assign o_buf_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
    end

endmodule

// File: rtl/matrix_load_ctrl.sv
// Load sequencer in front of the 5x5 reorder block: latches dimensions,
// collects r*c elements over valid/ready, pulses the reorder enable for a
// fixed window, then holds the result and reports done.
module matrix_load_ctrl #(
    parameter int DATA_WIDTH   = 9,
    parameter int MAX_DIM      = matrix_load_ctrl_pkg::MAX_DIM,
    parameter int ORDER_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_load_ctrl_if.slave       bus
);
    import matrix_load_ctrl_pkg::*;

    localparam int TW = (ORDER_CYCLES > 1) ? $clog2(ORDER_CYCLES) : 1;

    state_e           r_state;
    logic [2:0]       r_ord_r;
    logic [2:0]       r_ord_c;
    logic [IDX_W-1:0] r_total;
    logic [IDX_W-1:0] r_count;
    logic [TW-1:0]    r_win;
    logic             r_ord_en;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic                              w_idle_like;
    logic                              w_legal;
    logic                              w_accept;
    logic                              w_in_ready;
    logic                              w_xfer;
    logic                              w_last;
    logic [IDX_W-1:0]                  w_total;
    logic [TW-1:0]                     w_win_init;
    logic [MAT_ENTRIES*DATA_WIDTH-1:0] w_buf_flat;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_legal     = dim_legal(bus.dim_r, MAX_DIM) && dim_legal(bus.dim_c, MAX_DIM);
    assign w_accept    = w_idle_like && bus.start && !bus.cancel && w_legal;
    assign w_total     = {2'b00, bus.dim_r} * {2'b00, bus.dim_c};
    assign w_win_init  = TW'(ORDER_CYCLES - 1);

    // Ready is a pure state decode so the source may stream every cycle;
    // cancel suppresses the write even though ready is still high.
    assign w_in_ready  = (r_state == ST_LOAD);
    assign w_xfer      = w_in_ready && bus.in_valid && !bus.cancel;
    assign w_last      = w_xfer && ((r_count + IDX_W'(1)) == r_total);

    // Sequencer: cancel has priority over everything; outputs are registered.
    // NOTE: every state register uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ord_r  <= '0;
            r_ord_c  <= '0;
            r_total  <= '0;
            r_count  <= '0;
            r_win    <= '0;
            r_ord_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.cancel) begin
                r_state  <= ST_IDLE;
                r_count  <= '0;
                r_ord_en <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            if (w_legal) begin
                                r_state <= ST_LOAD;
                                r_ord_r <= bus.dim_r;
                                r_ord_c <= bus.dim_c;
                                r_total <= w_total;
                                r_count <= '0;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (w_xfer) begin
                            r_count <= r_count + IDX_W'(1);
                            if (w_last) begin
                                r_state  <= ST_ORDER;
                                r_ord_en <= 1'b1;
                                r_win    <= w_win_init;
                            end
                        end
                    end
                    ST_ORDER: begin
                        if (r_win == '0) begin
                            r_state  <= ST_DONE;
                            r_ord_en <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_win <= r_win - TW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    matrix_elem_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_accept),
        .i_we       (w_xfer),
        .i_waddr    (r_count),
        .i_wdata    (bus.in_data),
        .o_buf_flat (w_buf_flat)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.ord_r    = r_ord_r;
    assign bus.ord_c    = r_ord_c;
    assign bus.ord_en   = r_ord_en;
    assign bus.buf_flat = w_buf_flat;
    assign bus.count    = r_count;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
